mips_run_ctrl: RTL

- Parametrised reset sequencer and run supervisor for the pipelined MIPS core. It replaces the fixed single reset pulse and free-running clock harness.
- Holds the core in reset for a programmable number of cycles, then supervises execution.
- Counts cycles and retired instructions.
- Declares completion on a self-loop (branch-to-self halt idiom) or on a cycle timeout.
- Supports restart without a global reset.

---
 rtl/mips_run_ctrl_pkg.sv | 18 +
 rtl/mips_run_ctrl_if.sv | 25 ++
 rtl/mips_run_ctrl_loop_det.sv | 44 ++++
 rtl/mips_run_ctrl.sv | 127 ++++++++++++
 4 files changed

// File: rtl/mips_run_ctrl_pkg.sv
// Shared state encoding and constants for the MIPS run controller.
package mips_run_pkg;

   localparam int STATE_W = 2;

   localparam logic [STATE_W-1:0] ST_RST  = 2'd0;
   localparam logic [STATE_W-1:0] ST_RUN  = 2'd1;
   localparam logic [STATE_W-1:0] ST_DONE = 2'd2;

   typedef enum logic [STATE_W-1:0] {
      S_RST  = ST_RST,
      S_RUN  = ST_RUN,
      S_DONE = ST_DONE
   } run_state_t;

   localparam logic [31:0] HALT_PC_DEFAULT = 32'h0000_3ffc;

endpackage

// File: rtl/mips_run_ctrl_if.sv
// Control/status bundle between the run controller and the core harness.
interface mips_run_ctrl_if #(
   parameter int PC_W  = 32,
   parameter int CNT_W = 32
);
   logic             start;
   logic             pc_valid;
   logic [PC_W-1:0]  pc;
   logic             cpu_reset;
   logic             running;
   logic             done;
   logic             timed_out;
   logic [CNT_W-1:0] cycle_count;
   logic [CNT_W-1:0] instr_count;

   modport master (
      output start, pc_valid, pc,
      input  cpu_reset, running, done, timed_out, cycle_count, instr_count
   );

   modport slave (
      input  start, pc_valid, pc,
      output cpu_reset, running, done, timed_out, cycle_count, instr_count
   );
endinterface

// File: rtl/mips_run_ctrl_loop_det.sv
// Repeated-PC detector: hit pulses on the retirement that completes IDLE_LIMIT back-to-back repeats.
module mips_loop_det #(
   parameter int IDLE_LIMIT = 8,
   parameter int PC_W       = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            clr,
   input  logic            en,
   input  logic            pc_valid,
   input  logic [PC_W-1:0] pc,
   output logic            hit
);
   localparam int SC_W = $clog2(IDLE_LIMIT + 1);
   localparam logic [SC_W-1:0] SC_LAST = SC_W'(IDLE_LIMIT - 1);

   logic [PC_W-1:0] last_pc_q;
   logic            valid_q;
   logic [SC_W-1:0] same_cnt_q;
   logic            repeat_pc;

   assign repeat_pc = valid_q && (pc == last_pc_q);
   assign hit       = en && pc_valid && repeat_pc && (same_cnt_q == SC_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_pc_q  <= '0;
         valid_q    <= 1'b0;
         same_cnt_q <= '0;
      end else if (clr) begin
         last_pc_q  <= '0;
         valid_q    <= 1'b0;
         same_cnt_q <= '0;
      end else if (en && pc_valid) begin
         if (repeat_pc) begin
            same_cnt_q <= same_cnt_q + 1'b1;
         end else begin
            last_pc_q  <= pc;
            valid_q    <= 1'b1;
            same_cnt_q <= '0;
         end
      end
   end
endmodule

// File: rtl/mips_run_ctrl.sv
// Reset sequencer and run supervisor for the pipelined MIPS core.
// Define MIPS_RUN_CTRL_PC_HALT_EN to also finish on a retirement at HALT_PC.
//
// state | meaning
// RST   | core held in reset while rst_cnt counts RESET_CYCLES edges
// RUN   | core executing; cycle/instruction counters and loop detect live
// DONE  | halted (self-loop/halt PC) or timed out; counters frozen until start
module mips_run_ctrl
   import mips_run_pkg::*;
#(
   parameter int RESET_CYCLES   = 4,
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int IDLE_LIMIT     = 8,
   parameter int CNT_W          = 32,
   parameter int PC_W           = 32
`ifdef MIPS_RUN_CTRL_PC_HALT_EN
   ,
   parameter logic [PC_W-1:0] HALT_PC = PC_W'(HALT_PC_DEFAULT)
`endif
) (
   input logic            clk,
   input logic            reset,
   mips_run_ctrl_if.slave bus
);
   localparam int RC_W = $clog2(RESET_CYCLES) + 1;
   localparam logic [RC_W-1:0]  RST_LAST = RC_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   run_state_t       state_q, state_d;
   logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
   logic [CNT_W-1:0] cyc_q, cyc_d;
   logic [CNT_W-1:0] ins_q, ins_d;
   logic             timed_q, timed_d;
   logic             cpu_reset_q, running_q, done_q;
   logic             restart, in_run, loop_hit, halt_hit;

   assign in_run = (state_q == S_RUN);

   mips_loop_det #(
      .IDLE_LIMIT (IDLE_LIMIT),
      .PC_W       (PC_W)
   ) u_loop_det (
      .clk      (clk),
      .reset    (reset),
      .clr      (restart),
      .en       (in_run),
      .pc_valid (bus.pc_valid),
      .pc       (bus.pc),
      .hit      (loop_hit)
   );

`ifdef MIPS_RUN_CTRL_PC_HALT_EN
   assign halt_hit = in_run && bus.pc_valid && (bus.pc == HALT_PC);
`else
   assign halt_hit = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      rst_cnt_d = rst_cnt_q;
      cyc_d     = cyc_q;
      ins_d     = ins_q;
      timed_d   = timed_q;
      restart   = 1'b0;
      case (state_q)
         S_RST: begin
            rst_cnt_d = rst_cnt_q + 1'b1;
            if (rst_cnt_q == RST_LAST) begin
               state_d   = S_RUN;
               rst_cnt_d = '0;
            end
         end
         S_RUN: begin
            if (cyc_q != '1) cyc_d = cyc_q + 1'b1;
            if (bus.pc_valid && (ins_q != '1)) ins_d = ins_q + 1'b1;
            // a genuine halt outranks a timeout landing on the same edge
            if (halt_hit || loop_hit) begin
               state_d = S_DONE;
               timed_d = 1'b0;
            end else if (cyc_q == TMO_LAST) begin
               state_d = S_DONE;
               timed_d = 1'b1;
            end
         end
         S_DONE: begin
            if (bus.start) begin
               state_d   = S_RST;
               rst_cnt_d = '0;
               cyc_d     = '0;
               ins_d     = '0;
               timed_d   = 1'b0;
               restart   = 1'b1;
            end
         end
         default: state_d = S_RST;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_RST;
         rst_cnt_q   <= '0;
         cyc_q       <= '0;
         ins_q       <= '0;
         timed_q     <= 1'b0;
         cpu_reset_q <= 1'b1;
         running_q   <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rst_cnt_q   <= rst_cnt_d;
         cyc_q       <= cyc_d;
         ins_q       <= ins_d;
         timed_q     <= timed_d;
         cpu_reset_q <= (state_d == S_RST);
         running_q   <= (state_d == S_RUN);
         done_q      <= (state_d == S_DONE);
      end
   end

   assign bus.cpu_reset   = cpu_reset_q;
   assign bus.running     = running_q;
   assign bus.done        = done_q;
   assign bus.timed_out   = timed_q;
   assign bus.cycle_count = cyc_q;
   assign bus.instr_count = ins_q;
endmodule
